// File: rtl/seq_bin2bcd_if.sv
// Handshake and data bundle for the sequential 8-bit binary to 3-digit BCD converter.
// The master drives start/bin and receives busy/valid plus the three registered digits.
interface seq_bin2bcd_if;
    logic       start;
    logic [7:0] bin;
    logic       busy;
    logic       valid;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] hunds;

    modport master (
        output start, bin,
        input  busy, valid, ones, tens, hunds
    );

    modport slave (
        input  start, bin,
        output busy, valid, ones, tens, hunds
    );
endinterface

// File: rtl/seq_bin2bcd.sv
// Sequential double-dabble converter: 8-bit unsigned in, 3 BCD digits out after 10 cycles.
// Optional macro SEQ_BIN2BCD_CHANGE_DETECT_EN self-starts a conversion when bin differs from the last converted value.
module seq_bin2bcd (
    input  logic          clock,
    input  logic          reset,
    seq_bin2bcd_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  operand_q, operand_d;
    logic [11:0] scratch_q, scratch_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic [3:0]  ones_q, ones_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  hunds_q, hunds_d;
    logic [11:0] corr;
    logic        go;
`ifdef SEQ_BIN2BCD_CHANGE_DETECT_EN
    logic [7:0]  last_q, last_d;
`endif

    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        ones_d    = ones_q;
        tens_d    = tens_q;
        hunds_d   = hunds_q;
`ifdef SEQ_BIN2BCD_CHANGE_DETECT_EN
        last_d    = last_q;
        go        = bus.start || (bus.bin != last_q);
`else
        go        = bus.start;
`endif
        // Correction is applied per nibble on pre-shift values; no inter-nibble carry.
        corr = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};

        case (state_q)
            IDLE: begin
                if (go) begin
                    operand_d = bus.bin;
                    scratch_d = 12'd0;
                    cnt_d     = 3'd0;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
`ifdef SEQ_BIN2BCD_CHANGE_DETECT_EN
                    last_d    = bus.bin;
`endif
                end
            end
            SHIFT: begin
                {scratch_d, operand_d} = {corr, operand_q} << 1;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                hunds_d = scratch_q[11:8];
                tens_d  = scratch_q[7:4];
                ones_d  = scratch_q[3:0];
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            operand_q <= 8'd0;
            scratch_q <= 12'd0;
            cnt_q     <= 3'd0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            ones_q    <= 4'd0;
            tens_q    <= 4'd0;
            hunds_q   <= 4'd0;
`ifdef SEQ_BIN2BCD_CHANGE_DETECT_EN
            last_q    <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            operand_q <= operand_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            hunds_q   <= hunds_d;
`ifdef SEQ_BIN2BCD_CHANGE_DETECT_EN
            last_q    <= last_d;
`endif
        end
    end

    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
    assign bus.ones  = ones_q;
    assign bus.tens  = tens_q;
    assign bus.hunds = hunds_q;
endmodule

// File: tb/tb_seq_bin2bcd.sv
// Randomized self-checking bench for seq_bin2bcd; expected digits come from plain decimal arithmetic.
// Build with SEQ_BIN2BCD_CHANGE_DETECT_EN defined to exercise the self-start feature.
module tb_seq_bin2bcd;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    seq_bin2bcd_if bus ();

    seq_bin2bcd dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full conversion of v; bin is scrambled while busy when wiggle is set.
    task automatic convert(input string tag, input logic [7:0] v, input bit wiggle);
        logic [11:0] prev;
        int          n;
        bit          hold_ok;
        bit          busy_ok;
        prev    = {bus.hunds, bus.tens, bus.ones};
        hold_ok = 1'b1;
        busy_ok = 1'b1;
        bus.bin   = v;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk({tag, "_busy_rise"}, bus.busy, 1);
        n = 0;
        while (n < 20) begin
            if (wiggle) bus.bin = 8'($urandom);
            tick();
            n++;
            if (bus.valid) break;
            if ({bus.hunds, bus.tens, bus.ones} !== prev) hold_ok = 1'b0;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end
        bus.bin = v;
        chk({tag, "_latency"}, n, 9);
        chk({tag, "_outputs_held"}, hold_ok, 1);
        chk({tag, "_busy_held"}, busy_ok, 1);
        chk({tag, "_busy_fall"}, bus.busy, 0);
        chk({tag, "_hunds"}, bus.hunds, v / 100);
        chk({tag, "_tens"}, bus.tens, (v / 10) % 10);
        chk({tag, "_ones"}, bus.ones, v % 10);
        tick();
        chk({tag, "_valid_pulse"}, bus.valid, 0);
    endtask

    initial begin
        int n;
        int n1;
        int n2;
        int vcnt;
        logic [11:0] r1;
        logic [11:0] r2;
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.bin   = 8'd0;
        #1 reset = 1'b1;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_digits", {bus.hunds, bus.tens, bus.ones}, 0);
        repeat (2) tick();
        reset = 1'b0;
        tick();

        convert("c255", 8'd255, 1'b0);
        convert("c0", 8'd0, 1'b0);
        convert("c109", 8'd109, 1'b0);
        convert("c99", 8'd99, 1'b0);

        // Start and new bin while busy must be ignored.
        bus.bin   = 8'd37;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (2) tick();
        bus.bin   = 8'd200;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.bin   = 8'd37;
        n = 3; vcnt = 0; r1 = '0;
        while (n < 25) begin
            tick();
            n++;
            if (bus.valid) begin
                vcnt++;
                if (vcnt == 1) begin
                    n1 = n;
                    r1 = {bus.hunds, bus.tens, bus.ones};
                end
            end
        end
        chk("busy_ign_count", vcnt, 1);
        chk("busy_ign_latency", n1, 9);
        chk("busy_ign_result", r1, 12'h037);
        chk("busy_ign_idle", bus.busy, 0);

        // Asynchronous reset mid-conversion.
        bus.bin   = 8'd128;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        #1;
        chk("abort_digits", {bus.hunds, bus.tens, bus.ones}, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_valid", bus.valid, 0);
        bus.bin = 8'd0;
        #2 reset = 1'b0;
        vcnt = 0;
        repeat (14) begin
            tick();
            if (bus.valid) vcnt++;
        end
        chk("abort_no_valid", vcnt, 0);

        // Start held high: back-to-back conversions.
        bus.bin   = 8'd1;
        bus.start = 1'b1;
        tick();
        bus.bin = 8'd2;
        n = 0; vcnt = 0; n1 = 0; n2 = 0; r1 = '0; r2 = '0;
        while (n < 30 && vcnt < 2) begin
            tick();
            n++;
            if (bus.valid) begin
                vcnt++;
                if (vcnt == 1) begin
                    n1 = n;
                    r1 = {bus.hunds, bus.tens, bus.ones};
                end else begin
                    n2 = n;
                    r2 = {bus.hunds, bus.tens, bus.ones};
                end
            end
        end
        bus.start = 1'b0;
        chk("held_count", vcnt, 2);
        chk("held_first_latency", n1, 9);
        chk("held_spacing", n2 - n1, 10);
        chk("held_r1", r1, 12'h001);
        chk("held_r2", r2, 12'h002);
        tick();
        chk("held_stop", bus.busy, 0);

        for (int i = 0; i < 16; i++) begin
            convert($sformatf("rnd%0d", i), 8'($urandom), 1'b1);
        end

`ifdef SEQ_BIN2BCD_CHANGE_DETECT_EN
        // Self-start on a changed bin with start tied low.
        bus.start = 1'b0;
        bus.bin   = 8'd42;
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (bus.valid) break;
        end
        chk("cd_latency", n, 10);
        chk("cd_result", {bus.hunds, bus.tens, bus.ones}, 12'h042);
        vcnt = 0;
        repeat (15) begin
            tick();
            if (bus.valid) vcnt++;
        end
        chk("cd_steady", vcnt, 0);
`else
        // Without start nothing converts, even when bin changes.
        bus.start = 1'b0;
        bus.bin   = bus.bin + 8'd42;
        vcnt = 0;
        repeat (15) begin
            tick();
            if (bus.valid || bus.busy) vcnt++;
        end
        chk("no_self_start", vcnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_bin2bcd.md
SEQ_BIN2BCD -- requirements
Module: seq_bin2bcd

Interface
REQ-001 Parameters: none; input width fixed at 8 bits, output fixed at 3 BCD digits.
REQ-002 clock  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  conversion request; sampled only in IDLE.
REQ-005 bin  input  8  unsigned binary operand (switch value).
REQ-006 busy  output  1  high while a conversion is in progress (SHIFT and DONE).
REQ-007 valid  output  1  one-cycle pulse; new digits present on ones/tens/hunds.
REQ-008 ones  output  4  BCD units digit, registered.
REQ-009 tens  output  4  BCD tens digit, registered.
REQ-010 hunds  output  4  BCD hundreds digit, registered, range 0..2.

Function
REQ-011 FSM states IDLE, SHIFT, DONE; one-hot or binary encoding at implementer's choice.
REQ-012 IDLE and start=1 at edge k: latch bin into operand register, clear 12-bit scratch, clear 3-bit iteration counter, go to SHIFT, busy=1.
REQ-013 SHIFT, edges k+1..k+8: one double-dabble iteration per edge -- each scratch nibble >=5 gets +3, then {scratch,operand} shifts left by 1.
REQ-014 Add-3 correction SHALL use the scratch values before the shift of the same iteration; nibble arithmetic 4-bit, no carry between nibbles.
REQ-015 Edge k+8 (8th iteration): go to DONE; iteration counter wraps 7->0 at this edge.
REQ-016 Edge k+9: load ones/tens/hunds from final scratch, valid=1 for exactly one cycle, busy=0, go to IDLE.
REQ-017 Latency: start sampled at edge k -> valid high in the cycle following edge k+9; minimum start-to-start spacing 10 cycles.
REQ-018 Outputs hold last converted value until next DONE; they SHALL NOT change during SHIFT.
REQ-019 start while busy=1 ignored; bin changes after edge k do not affect the running conversion.
REQ-020 start high in the cycle valid is high (state IDLE) is accepted at the next edge (back-to-back).
REQ-021 start held high continuously: conversions repeat every 10 cycles.

Reset
REQ-022 reset=1: state IDLE, busy=0, valid=0, ones=tens=hunds=0, operand, scratch, counter = 0, immediately, independent of clock.
REQ-023 reset asserted mid-conversion aborts it; no valid pulse for the aborted operand.
REQ-024 First edge after reset deassertion behaves as IDLE.

Configuration
REQ-025 Macro SEQ_BIN2BCD_CHANGE_DETECT_EN.
REQ-026 Defined: an 8-bit last-converted register (reset 0), loaded at REQ-012. In IDLE, bin != last-converted self-starts a conversion exactly as start=1; start port still honoured.
REQ-027 Not defined: conversions begin only on start; no last-converted register is synthesised.

Verification
REQ-028 After reset: bin=8'd255, start pulse at edge k -> valid at edge k+9, hunds=2 tens=5 ones=5, busy high k..k+8.
REQ-029 bin=0 start -> 0/0/0 with valid; bin=8'd109 start -> 1/0/9; bin=8'd99 -> 0/9/9.
REQ-030 During busy after bin=8'd37 start: bin=8'd200 and start=1 at k+3 -> result 0/3/7, single valid pulse, no second conversion started.
REQ-031 reset pulse at k+4 during bin=8'd128 conversion -> outputs 0/0/0 immediately, no valid pulse, busy=0.
REQ-032 start held high, bin=8'd1 then 8'd2 -> valid pulses 10 cycles apart, results 0/0/1 then 0/0/2.
REQ-033 With SEQ_BIN2BCD_CHANGE_DETECT_EN, start tied 0: bin 0->8'd42 -> valid with 0/4/2 after 10 cycles; bin steady -> no further valid.
